// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a 2-entry skid buffer and registered in_ready.
// Optional backpressure cycle counter enabled by PIPE_STALL_CNT_EN.
module pipe_skid_stage #(
  parameter int                DATA_W     = 96,
  parameter logic [DATA_W-1:0] RESET_DATA = '0
`ifdef PIPE_STALL_CNT_EN
  , parameter int              CNT_W      = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  // state    | meaning
  // ST_EMPTY | nothing held (m_v=0, s_v=0)
  // ST_BUSY  | main register holds a beat (m_v=1, s_v=0)
  // ST_FULL  | main and skid both hold beats (m_v=1, s_v=1)
  // Encoding keeps bit0 = m_v and bit1 = s_v so the handshake outputs are bare flop bits.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] m_d_q, m_d_d;
  logic [DATA_W-1:0] s_d_q, s_d_d;
  logic              accept;
  logic              deliver;

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_d_q   <= RESET_DATA;
      s_d_q   <= RESET_DATA;
    end else begin
      state_q <= state_d;
      m_d_q   <= m_d_d;
      s_d_q   <= s_d_d;
    end
  end

  always_comb begin
    state_d = state_q;
    m_d_d   = m_d_q;
    s_d_d   = s_d_q;
    if (flush) begin
      state_d = ST_EMPTY;
      m_d_d   = RESET_DATA;
      s_d_d   = RESET_DATA;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_BUSY;
            m_d_d   = in_data;
          end
        end
        ST_BUSY: begin
          if (accept && deliver) begin
            m_d_d = in_data;
          end else if (accept) begin
            state_d = ST_FULL;
            s_d_d   = in_data;
          end else if (deliver) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // The skid beat is older than anything upstream, so it refills main first.
          if (deliver) begin
            state_d = ST_BUSY;
            m_d_d   = s_d_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = ~state_q[1];
    out_valid = state_q[0];
    out_data  = m_d_q;
  end

`ifdef PIPE_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count; flush deliberately leaves it alone.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule
